// File: rtl/regfile_pkg.sv
// regfile_pkg: shared state encoding, default sizes and depth helper for regfile_mp
package regfile_pkg;
  localparam int DATA_W_DEF = 32;
  localparam int ADDR_W_DEF = 5;
  localparam int NUM_RD_DEF = 2;
  localparam int DEPTH_DEF  = 2 ** ADDR_W_DEF;
  typedef enum logic {S_CLEAR = 1'b0, S_READY = 1'b1} state_e;
  function automatic int depth_of(input int aw);
    return 2 ** aw;
  endfunction
endpackage

// File: rtl/regfile_mp_if.sv
// regfile_mp_if: decode/writeback bus of regfile_mp; master drives addresses and writes
interface regfile_mp_if import regfile_pkg::*; #(
  parameter int DATA_W = DATA_W_DEF,
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int NUM_RD = NUM_RD_DEF
);
  logic [NUM_RD*ADDR_W-1:0] rd_addr;
  logic [NUM_RD*DATA_W-1:0] rd_data;
  logic [NUM_RD-1:0]        rd_pend;
  logic                     wr_en;
  logic [ADDR_W-1:0]        wr_addr;
  logic [DATA_W-1:0]        wr_data;
  logic                     pend_set;
  logic [ADDR_W-1:0]        pend_addr;
  logic                     ready;
  modport master (output rd_addr, wr_en, wr_addr, wr_data, pend_set, pend_addr,
                  input rd_data, rd_pend, ready);
  modport slave  (input rd_addr, wr_en, wr_addr, wr_data, pend_set, pend_addr,
                  output rd_data, rd_pend, ready);
endinterface

// File: rtl/regfile_scoreboard.sv
// regfile_scoreboard: per-register pending bits; set beats clear, register 0 never pends
module regfile_scoreboard import regfile_pkg::*; #(
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int NUM_RD = NUM_RD_DEF
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     en,
  input  logic                     set,
  input  logic [ADDR_W-1:0]        set_addr,
  input  logic                     clr,
  input  logic [ADDR_W-1:0]        clr_addr,
  input  logic [NUM_RD*ADDR_W-1:0] rd_addr,
  output logic [NUM_RD-1:0]        rd_pend
);
  localparam int DEPTH = depth_of(ADDR_W);
  logic [DEPTH-1:0] pend, set_vec, clr_vec;
  always_comb begin
    set_vec = en && set && set_addr != '0 ? DEPTH'(1) << set_addr : '0;
    clr_vec = en && clr ? DEPTH'(1) << clr_addr : '0;
    for (int i = 0; i < NUM_RD; i++) rd_pend[i] = pend[rd_addr[i*ADDR_W +: ADDR_W]];
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) pend <= '0;
    else pend <= (pend & ~clr_vec) | set_vec;
endmodule

// File: rtl/regfile_mp.sv
// regfile_mp: multi-read-port register file with post-reset clear and pending scoreboard.
// Define REGFILE_BYPASS_EN for same-cycle write-to-read bypass.
module regfile_mp import regfile_pkg::*; #(
  parameter int DATA_W = DATA_W_DEF,
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int NUM_RD = NUM_RD_DEF
) (
  input logic clk,
  input logic rst_n,
  regfile_mp_if.slave bus
);
  localparam int DEPTH = depth_of(ADDR_W);
  state_e                   state;
  logic [ADDR_W:0]          clr_idx;
  logic [DATA_W-1:0]        regmem [DEPTH];
  logic                     ready, wr_hit;
  logic [ADDR_W-1:0]        addr [NUM_RD];
  logic [NUM_RD-1:0]        byp, pend_raw, rd_pend;
  logic [NUM_RD*DATA_W-1:0] rd_data;
  assign ready  = state == S_READY;
  assign wr_hit = ready && bus.wr_en && bus.wr_addr != '0;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state   <= S_CLEAR;
      clr_idx <= '0;
    end else if (!ready) begin
      clr_idx <= clr_idx + 1'b1;
      state   <= clr_idx == (ADDR_W+1)'(DEPTH-1) ? S_READY : S_CLEAR;
    end
  // storage has no reset; the clear sequence zeroes it instead
  always_ff @(posedge clk)
    if (!ready) regmem[clr_idx[ADDR_W-1:0]] <= '0;
    else if (wr_hit) regmem[bus.wr_addr] <= bus.wr_data;
  regfile_scoreboard #(.ADDR_W(ADDR_W), .NUM_RD(NUM_RD)) u_sb (
    .clk(clk), .rst_n(rst_n), .en(ready),
    .set(bus.pend_set), .set_addr(bus.pend_addr),
    .clr(bus.wr_en), .clr_addr(bus.wr_addr),
    .rd_addr(bus.rd_addr), .rd_pend(pend_raw)
  );
  always_comb
    for (int i = 0; i < NUM_RD; i++) begin
      addr[i] = bus.rd_addr[i*ADDR_W +: ADDR_W];
`ifdef REGFILE_BYPASS_EN
      byp[i] = wr_hit && addr[i] == bus.wr_addr;
`else
      byp[i] = 1'b0;
`endif
    end
  always_comb begin
    rd_data = '0;
    rd_pend = '0;
    for (int i = 0; i < NUM_RD; i++) begin
      rd_data[i*DATA_W +: DATA_W] = !ready || addr[i] == '0 ? '0 : byp[i] ? bus.wr_data : regmem[addr[i]];
      rd_pend[i] = ready && addr[i] != '0 && pend_raw[i] &&
                   (!byp[i] || (bus.pend_set && bus.pend_addr == bus.wr_addr));
    end
  end
  assign bus.rd_data = rd_data;
  assign bus.rd_pend = rd_pend;
  assign bus.ready   = ready;
endmodule

// File: tb/tb_regfile_mp.sv
// tb_regfile_mp: directed checks of clear sequence, read/write, scoreboard, bypass and mid-run reset
module tb_regfile_mp;
  logic clk = 1'b0;
  logic rst_n;
  int ncmp = 0;
  int nerr = 0;
  regfile_mp_if #(.DATA_W(32), .ADDR_W(5), .NUM_RD(3)) bus ();
  regfile_mp #(.DATA_W(32), .ADDR_W(5), .NUM_RD(3)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    ncmp++;
    assert (obs === exp) else begin
      nerr++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask
  function automatic logic [31:0] rdd(input int p);
    return bus.rd_data[p*32 +: 32];
  endfunction
  task automatic setrd(input logic [4:0] a0, input logic [4:0] a1, input logic [4:0] a2);
    bus.rd_addr = {a2, a1, a0};
    #1;
  endtask
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  initial begin
    rst_n = 1'b0;
    bus.rd_addr = '0;
    bus.wr_en = 1'b0;
    bus.wr_addr = '0;
    bus.wr_data = '0;
    bus.pend_set = 1'b0;
    bus.pend_addr = '0;
    #12;
    chk("rst_ready", 32'(bus.ready), 32'd0);
    chk("rst_pend", 32'(bus.rd_pend), 32'd0);
    chk("rst_data", rdd(0), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    for (int c = 0; c < 32; c++) begin
      bus.wr_en = c == 30;
      bus.wr_addr = 5'd5;
      bus.wr_data = 32'h0000DEAD;
      #1;
      chk($sformatf("clr_ready_c%0d", c), 32'(bus.ready), 32'd0);
      tick();
    end
    bus.wr_en = 1'b0;
    chk("ready_c32", 32'(bus.ready), 32'd1);
    for (int a = 0; a < 32; a++) begin
      setrd(5'(a), 5'd0, 5'd0);
      chk($sformatf("clr_zero_r%0d", a), rdd(0), 32'd0);
    end
    setrd(5'd5, 5'd5, 5'd5);
    chk("clr_wr_ignored", rdd(2), 32'd0);
    bus.wr_en = 1'b1; bus.wr_addr = 5'd7; bus.wr_data = 32'h12345678;
    tick();
    bus.wr_en = 1'b0;
    setrd(5'd7, 5'd7, 5'd0);
    chk("r7_p0", rdd(0), 32'h12345678);
    chk("r7_p1", rdd(1), 32'h12345678);
    chk("r0_p2", rdd(2), 32'd0);
    bus.wr_en = 1'b1; bus.wr_addr = 5'd0; bus.wr_data = 32'hFFFFFFFF;
    tick();
    bus.wr_en = 1'b0;
    setrd(5'd0, 5'd7, 5'd0);
    chk("r0_wr_dropped", rdd(0), 32'd0);
    chk("r7_kept", rdd(1), 32'h12345678);
    bus.pend_set = 1'b1; bus.pend_addr = 5'd9;
    setrd(5'd9, 5'd0, 5'd0);
    chk("pend9_pre", 32'(bus.rd_pend[0]), 32'd0);
    tick();
    bus.pend_set = 1'b0;
    #1;
    chk("pend9_set", 32'(bus.rd_pend[0]), 32'd1);
    bus.wr_en = 1'b1; bus.wr_addr = 5'd9; bus.wr_data = 32'h00000099;
    #1;
`ifdef REGFILE_BYPASS_EN
    chk("pend9_wr_same", 32'(bus.rd_pend[0]), 32'd0);
`else
    chk("pend9_wr_same", 32'(bus.rd_pend[0]), 32'd1);
`endif
    tick();
    bus.wr_en = 1'b0;
    #1;
    chk("pend9_cleared", 32'(bus.rd_pend[0]), 32'd0);
    chk("r9_data", rdd(0), 32'h00000099);
    bus.wr_en = 1'b1; bus.wr_addr = 5'd9; bus.wr_data = 32'h0000ABCD;
    bus.pend_set = 1'b1; bus.pend_addr = 5'd9;
    tick();
    bus.wr_en = 1'b0; bus.pend_set = 1'b0;
    #1;
    chk("pend9_set_wins", 32'(bus.rd_pend[0]), 32'd1);
    chk("r9_data_upd", rdd(0), 32'h0000ABCD);
    bus.pend_set = 1'b1; bus.pend_addr = 5'd0;
    tick();
    bus.pend_set = 1'b0;
    setrd(5'd0, 5'd9, 5'd0);
    chk("pend_r0", 32'(bus.rd_pend[0]), 32'd0);
    chk("pend9_still", 32'(bus.rd_pend[1]), 32'd1);
    setrd(5'd3, 5'd0, 5'd0);
    bus.wr_en = 1'b1; bus.wr_addr = 5'd3; bus.wr_data = 32'hA5A5A5A5;
    #1;
`ifdef REGFILE_BYPASS_EN
    chk("byp_same", rdd(0), 32'hA5A5A5A5);
`else
    chk("byp_same", rdd(0), 32'd0);
`endif
    tick();
    bus.wr_en = 1'b0;
    #1;
    chk("byp_next", rdd(0), 32'hA5A5A5A5);
    bus.wr_en = 1'b1; bus.wr_addr = 5'd4; bus.wr_data = 32'h00000055;
    tick();
    bus.wr_en = 1'b0;
    bus.pend_set = 1'b1; bus.pend_addr = 5'd4;
    tick();
    bus.pend_addr = 5'd5;
    tick();
    bus.pend_set = 1'b0;
    setrd(5'd4, 5'd5, 5'd0);
    chk("pre_rst_pend4", 32'(bus.rd_pend[0]), 32'd1);
    chk("pre_rst_pend5", 32'(bus.rd_pend[1]), 32'd1);
    chk("pre_rst_r4", rdd(0), 32'h00000055);
    tick();
    rst_n = 1'b0;
    #1;
    chk("mid_rst_ready", 32'(bus.ready), 32'd0);
    chk("mid_rst_pend", 32'(bus.rd_pend), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (31) tick();
    chk("mid_ready_c31", 32'(bus.ready), 32'd0);
    tick();
    chk("mid_ready_c32", 32'(bus.ready), 32'd1);
    chk("mid_r4_zero", rdd(0), 32'd0);
    chk("mid_pend4", 32'(bus.rd_pend[0]), 32'd0);
    chk("mid_pend5", 32'(bus.rd_pend[1]), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nerr);
    $finish;
  end
endmodule
